// File: rtl/tone_pkg.sv
// tone_pkg: shared constants and the base half-period table for the tone generator.
package tone_pkg;

    localparam int REST_CODE = 63;
    localparam int MAX_NOTE  = 47;
    localparam int HP_W      = 17;

    // Half-period in clk cycles for semitone i above A3 (220 Hz), rounded to nearest.
    function automatic logic [HP_W-1:0] base_hp(input int clk_hz, input int i);
        real r;
        case (i)
            1:       r = 1.0594630943592953;
            2:       r = 1.1224620483093730;
            3:       r = 1.1892071150027210;
            4:       r = 1.2599210498948732;
            5:       r = 1.3348398541700344;
            6:       r = 1.4142135623730951;
            7:       r = 1.4983070768766815;
            8:       r = 1.5874010519681994;
            9:       r = 1.6817928305074290;
            10:      r = 1.7817974362806785;
            11:      r = 1.8877486253633870;
            default: r = 1.0;
        endcase
        return HP_W'(int'(real'(clk_hz) / (440.0 * r)));
    endfunction

endpackage

// File: rtl/tone_gen_note_rom.sv
// note_rom: maps a note code to its half-period in clk cycles (0 for rest/invalid).
module note_rom
    import tone_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic [5:0]      code,
    output logic [HP_W-1:0] hp
);

    logic [HP_W-1:0] base [12];
    logic [1:0]      oct;
    logic [3:0]      semi;

    for (genvar g = 0; g < 12; g++) begin : g_base
        assign base[g] = base_hp(CLK_HZ, g);
    end

    always_comb begin
        oct  = code >= 6'd36 ? 2'd3 : code >= 6'd24 ? 2'd2 : code >= 6'd12 ? 2'd1 : 2'd0;
        semi = 4'(code - 6'(oct) * 6'd12);
        hp   = code > 6'(MAX_NOTE) ? '0 : base[semi] >> oct;
    end

endmodule

// File: rtl/tone_gen.sv
// tone_gen: square-wave buzzer driver; half-period counter toggles buzz for the current note.
module tone_gen
    import tone_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [5:0] music,
    output logic       buzz,
    output logic       note_on
);

    logic [5:0]      cur_code;
    logic [HP_W-1:0] hp;
    logic [HP_W-1:0] cnt;
    logic [HP_W-1:0] rom_hp;

    note_rom #(.CLK_HZ(CLK_HZ)) u_rom (
        .code (music),
        .hp   (rom_hp)
    );

    // note_on doubles as "cur_code is a valid note" since it is loaded alongside cur_code
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cur_code <= 6'(REST_CODE);
            hp       <= '0;
            cnt      <= '0;
            buzz     <= 1'b0;
            note_on  <= 1'b0;
        end else if (music != cur_code) begin
            cur_code <= music;
            hp       <= rom_hp;
            cnt      <= '0;
            buzz     <= 1'b0;
            note_on  <= music <= 6'(MAX_NOTE);
        end else if (note_on) begin
            cnt  <= cnt == hp - HP_W'(1) ? '0 : cnt + HP_W'(1);
            buzz <= cnt == hp - HP_W'(1) ? ~buzz : buzz;
        end
    end

endmodule

// File: tb/tb_tone_gen.sv
// tb_tone_gen: randomized scoreboard bench for tone_gen against a closed-form timing model.
module tb_tone_gen;
    import tone_pkg::*;

    localparam int HZ = 200_000;

    typedef struct {
        logic b;
        logic on;
        int   hp;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic [5:0]      music = 6'd63;
    logic            buzz, note_on;
    logic [5:0]      rcode = 6'd0;
    logic [HP_W-1:0] rhp;

    exp_t q[$];
    int   checks = 0, errors = 0;
    int   mcode = 63, mhp = 0, tload = 0, t = 0;
    bit   m_on = 1'b0, m_buzz = 1'b0;

    always #5 clk = ~clk;

    tone_gen #(.CLK_HZ(HZ)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .music   (music),
        .buzz    (buzz),
        .note_on (note_on)
    );

    note_rom rom50 (
        .code (rcode),
        .hp   (rhp)
    );

    function automatic int ref_hp(int n, int hz);
        real b;
        if (n > 47) return 0;
        b = real'(hz) / (440.0 * 2.0 ** (real'(n % 12) / 12.0));
        return int'(b) >> (n / 12);
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0d: got %0d expected %0d", name, t, act, exp);
        end
    endtask

    // Buzz is high during odd-numbered half-periods counted from the load edge.
    task automatic step(bit r, bit e, int m);
        rst   = r;
        en    = e;
        music = 6'(m);
        t++;
        if (r || !e) begin
            mcode = 63; mhp = 0; m_on = 0; m_buzz = 0;
        end else if (m != mcode) begin
            mcode = m; mhp = ref_hp(m, HZ); tload = t; m_on = (m <= 47); m_buzz = 0;
        end else begin
            m_buzz = m_on ? (((t - tload) / mhp) % 2 == 1) : 1'b0;
        end
        q.push_back('{m_buzz, m_on, mhp});
        @(posedge clk);
        #2;
    endtask

    task automatic hold(int n, bit r, bit e, int m);
        repeat (n) step(r, e, m);
    endtask

    initial begin : monitor
        forever begin : mon_blk
            exp_t x;
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check("buzz", int'(buzz), int'(x.b));
                check("note_on", int'(note_on), int'(x.on));
                check("hp", int'(dut.hp), x.hp);
            end
        end
    end

    initial begin : stim
        int codes[8] = '{15, 17, 27, 47, 0, 3, 50, 63};
        int exps[8]  = '{47778, 42565, 23889, 7524, 113636, 95556, 0, 0};
        int m, n, c;
        for (int i = 0; i < 8; i++) begin
            rcode = 6'(codes[i]);
            #1;
            check("rom50", int'(rhp), exps[i]);
        end
        hold(3, 1, 1, 63);
        hold(100, 0, 1, 63);
        hold(1000, 0, 1, 15);
        hold(300, 0, 1, 27);
        hold(900, 0, 1, 27);
        hold(200, 0, 1, 15);
        do step(0, 1, 15); while (!(m_buzz && (t - tload) % mhp == 50));
        hold(800, 0, 1, 17);
        hold(5, 0, 0, 17);
        hold(500, 0, 1, 17);
        hold(1, 1, 1, 17);
        hold(500, 0, 1, 17);
        hold(50, 0, 1, 50);
        hold(20, 0, 1, 49);
        hold(200, 0, 1, 47);
        hold(100, 0, 1, 62);
        repeat (40) begin
            m = $urandom_range(0, 99) < 80 ? $urandom_range(0, 47) : $urandom_range(48, 63);
            n = $urandom_range(1, 800);
            c = $urandom_range(0, 9);
            if (c == 0) hold($urandom_range(1, 5), 0, 0, m);
            else if (c == 1) hold(1, 1, 1, m);
            hold(n, 0, 1, m);
        end
        @(posedge clk);
        #3;
        check("drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
